// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator aging monitor: runs a reference and a stressed RO, counts their edges
// over a fixed clk window and reports both counts and their signed difference.
module ro_meas_ctrl #(
  parameter int SETTLE_CYCLES = 16,
  parameter int WINDOW_CYCLES = 1024,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stress_en,
  input  logic             ro_out_ref,
  input  logic             ro_out_str,
  output logic             en_ro_ref,
  output logic             en_ro_str,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count_ref,
  output logic [CNT_W-1:0] count_str,
  output logic [CNT_W:0]   delta
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    DRAIN,
    DONE
  } state_t;

  localparam int DRAIN_CYCLES = 3;
  localparam int MAX_SW       = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int MAX_DUR      = (MAX_SW > DRAIN_CYCLES) ? MAX_SW : DRAIN_CYCLES;
  localparam int TMR_W        = $clog2(MAX_DUR);

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] DRAIN_LAST  = TMR_W'(DRAIN_CYCLES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [TMR_W-1:0]   timer;
  logic               timer_clr;
  logic               accept;
  logic               capture;

  logic [2:0]         sync_ref;
  logic [2:0]         sync_str;
  logic               edge_ref;
  logic               edge_str;
  logic               counting;

  // ---------------------------------------------------------------------------
  // Sequencer: one shared timer measures the length of every timed state.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
    state_nxt = state;
    timer_clr = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    en_ro_ref = 1'b0;
    en_ro_str = 1'b0;

    unique case (state)
      IDLE: begin
        busy      = 1'b0;
        en_ro_str = stress_en & ~rst;
        if (start) begin
          state_nxt = SETTLE;
          timer_clr = 1'b1;
          accept    = 1'b1;
        end
      end
      SETTLE: begin
        en_ro_ref = 1'b1;
        en_ro_str = 1'b1;
        if (timer == SETTLE_LAST) begin
          state_nxt = MEASURE;
          timer_clr = 1'b1;
        end
      end
      MEASURE: begin
        en_ro_ref = 1'b1;
        en_ro_str = 1'b1;
        if (timer == WINDOW_LAST) begin
          state_nxt = DRAIN;
          timer_clr = 1'b1;
        end
      end
      DRAIN: begin
        if (timer == DRAIN_LAST) begin
          state_nxt = DONE;
          timer_clr = 1'b1;
          capture   = 1'b1;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
        timer_clr = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        timer_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      if (timer_clr || state == IDLE) begin
        timer <= '0;
      end else begin
        timer <= timer + TMR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RO capture: 2-flop synchronizer plus a third flop for rising-edge detect.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the synchronizer is reset as well, so a stale level cannot look like an edge after reset.
    if (rst) begin
      sync_ref <= '0;
      sync_str <= '0;
    end else begin
      sync_ref <= {sync_ref[1:0], ro_out_ref};
      sync_str <= {sync_str[1:0], ro_out_str};
    end
  end

  assign edge_ref = sync_ref[1] & ~sync_ref[2];
  assign edge_str = sync_str[1] & ~sync_str[2];

  // Only edges that emerge while the window is open are counted; late ones are dropped.
  assign counting = (state == MEASURE);

  // ---------------------------------------------------------------------------
  // Saturating counters and the difference captured on entry to DONE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_ref <= '0;
      count_str <= '0;
      delta     <= '0;
    end else if (accept) begin
      count_ref <= '0;
      count_str <= '0;
      delta     <= '0;
    end else begin
      if (counting && edge_ref && count_ref != '1) begin
        count_ref <= count_ref + CNT_W'(1);
      end
      if (counting && edge_str && count_str != '1) begin
        count_str <= count_str + CNT_W'(1);
      end
      if (capture) begin
        delta <= {1'b0, count_ref} - {1'b0, count_str};
      end
    end
  end

endmodule

// File: doc/ro_meas_ctrl.md
RO_MEAS_CTRL -- requirements
Module: ro_meas_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 16: clk cycles the ROs run before counting opens.
REQ-002 The block SHALL have parameter WINDOW_CYCLES, default 1024: clk cycles of the counting window.
REQ-003 The block SHALL have parameter CNT_W, default 16: width of each edge counter.
REQ-004 The block SHALL have port clk, input, 1: the single system clock, rising-edge.
REQ-005 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1: request for one measurement, sampled only in IDLE.
REQ-007 The block SHALL have port stress_en, input, 1: keeps the stressed RO enabled while IDLE (aging mode).
REQ-008 The block SHALL have port ro_out_ref, input, 1: asynchronous output of the reference ring oscillator.
REQ-009 The block SHALL have port ro_out_str, input, 1: asynchronous output of the stressed ring oscillator.
REQ-010 The block SHALL have port en_ro_ref, output, 1: enable for the reference RO.
REQ-011 The block SHALL have port en_ro_str, output, 1: enable for the stressed RO.
REQ-012 The block SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1: one-cycle pulse when the results are valid.
REQ-014 The block SHALL have port count_ref, output, CNT_W: rising edges of the reference RO seen in the window.
REQ-015 The block SHALL have port count_str, output, CNT_W: rising edges of the stressed RO seen in the window.
REQ-016 The block SHALL have port delta, output, CNT_W+1: signed count_ref minus count_str.

Function
REQ-017 The block SHALL implement the FSM states IDLE, SETTLE, MEASURE, DRAIN and DONE.
REQ-018 IDLE SHALL move to SETTLE on the clock edge where start=1; IDLE otherwise holds.
REQ-019 On the IDLE->SETTLE transition, both counters and delta SHALL clear to 0.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then move to MEASURE.
REQ-021 MEASURE SHALL last exactly WINDOW_CYCLES cycles, then move to DRAIN.
REQ-022 DRAIN SHALL last exactly 3 cycles, then move to DONE.
REQ-023 DONE SHALL last 1 cycle, then move to IDLE.
REQ-024 en_ro_ref SHALL be 1 only in SETTLE and MEASURE.
REQ-025 en_ro_str SHALL be 1 in SETTLE and MEASURE, and also in IDLE when stress_en=1; it SHALL be 0 in DRAIN and DONE.
REQ-026 Each ro_out input SHALL pass through a 2-flop synchronizer followed by a rising-edge detector (third flop).
REQ-027 A detected edge SHALL increment its counter only while in MEASURE.
REQ-028 Edges still in the synchronizer pipeline when MEASURE ends SHALL be discarded.
REQ-029 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-030 delta SHALL be registered on entry to DONE, sign-extended to CNT_W+1 bits.
REQ-031 done SHALL be 1 only in DONE.
REQ-032 count_ref, count_str and delta SHALL hold their values from DONE until the next IDLE->SETTLE transition.
REQ-033 start SHALL be ignored while busy=1; a start asserted in the same cycle as DONE SHALL be ignored.
REQ-034 Correct counts SHALL be guaranteed only for RO frequencies below clk/2; faster ROs SHALL alias, with no error flag.
REQ-035 Total latency from start sampled to done SHALL be SETTLE_CYCLES+WINDOW_CYCLES+4 cycles.

Reset
REQ-036 While rst=1, the FSM SHALL be IDLE; busy, done and en_ro_ref SHALL be 0; counters, delta and the synchronizer flops SHALL be 0.
REQ-037 While rst=1, en_ro_str SHALL be 0 regardless of stress_en.
REQ-038 Reset asserted mid-measurement SHALL abort it immediately and asynchronously, drop both enables, and produce no done pulse.
REQ-039 After rst deasserts, the block SHALL return to normal operation with no further action, including stress_en control of en_ro_str in IDLE.

Verification
REQ-040 Bench: clk 100 MHz, SETTLE_CYCLES=4, WINDOW_CYCLES=100, reference RO period 40 ns, stressed RO period 50 ns, start pulsed -> done at cycle 108 after start; count_ref=25±1, count_str=20±1, delta=+5±2.
REQ-041 Bench: stress_en=1 in IDLE -> en_ro_str=1 and en_ro_ref=0; en_ro_str drops in DRAIN and DONE, then returns to 1 in IDLE.
REQ-042 Bench: CNT_W=4, reference RO period 40 ns, WINDOW_CYCLES=100 -> count_ref=15 (saturated, no wrap).
REQ-043 Bench: start re-pulsed during MEASURE and during DONE -> no restart; exactly one done pulse; counts unchanged.
REQ-044 Bench: rst pulsed during MEASURE -> en_ro_ref, en_ro_str, busy and counts are 0 within the same cycle; no done pulse; the next start produces a full, correct measurement.
REQ-045 Bench: ro_out inputs held at 0 -> count_ref=0, count_str=0, delta=0, and done still arrives at the nominal latency.
